qdeact_axis: RTL

- Streaming dequantizer: inverse direction of the quantized-activation path.
- Takes N unsigned quantized lanes plus a per-lane signed scale.
- Computes the product, re-aligns it to a signed fixed-point output format, rounds and saturates.
- Two-stage pipeline with AXI-stream-style valid/ready on both sides; sits between activation storage and the next layer's fixed-point datapath.

---
 rtl/qdeact_axis.sv | 78 +++++++
 1 files changed

// File: rtl/qdeact_axis.sv
// qdeact_axis: two-stage streaming dequantizer; q*scale realigned to signed fixed point
// with round-half-up and saturation, valid/ready on both sides.
module qdeact_axis #(
  parameter int N   = 4,
  parameter int QB  = 8,
  parameter int QBF = 4,
  parameter int SB  = 8,
  parameter int SBF = 6,
  parameter int YB  = 12,
  parameter int YBF = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [N-1:0][QB-1:0]  s_data,
  input  logic [N-1:0][SB-1:0]  s_scale,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [N-1:0][YB-1:0]  m_data,
  output logic                  m_last,
  input  logic                  sat_clr,
  output logic                  sat_flag
);
  localparam int PW = QB + 1 + SB;
  localparam int SH = QBF + SBF - YBF;
  localparam logic signed [PW:0] RND  = (PW+1)'((2 ** SH) / 2);
  localparam logic signed [PW:0] YMAX = (PW+1)'(2 ** (YB-1) - 1);
  localparam logic signed [PW:0] YMIN = -YMAX - (PW+1)'(1);
  if (QBF + SBF < YBF) begin : g_bad_fmt
    $error("qdeact_axis: QBF+SBF must be >= YBF");
  end
  logic v1, v2, last1, free1, free2;
  logic [N-1:0][PW-1:0] p_q;
  logic [N-1:0][YB-1:0] y_d;
  logic [N-1:0] sat_d;
  logic signed [PW:0] r [N];
  assign free2   = !v2 || m_ready;
  assign free1   = !v1 || free2;
  assign s_ready = free1;
  assign m_valid = v2;
  // one guard bit above the product keeps the rounding add from overflowing
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign r[i]     = ($signed({p_q[i][PW-1], p_q[i]}) + RND) >>> SH;
    assign sat_d[i] = r[i] > YMAX || r[i] < YMIN;
    assign y_d[i]   = r[i] > YMAX ? YMAX[YB-1:0] : r[i] < YMIN ? YMIN[YB-1:0] : r[i][YB-1:0];
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      last1    <= 1'b0;
      p_q      <= '0;
      m_data   <= '0;
      m_last   <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      if (free1) begin
        v1 <= s_valid;
        if (s_valid) begin
          last1 <= s_last;
          for (int k = 0; k < N; k++)
            p_q[k] <= PW'($signed({1'b0, s_data[k]})) * PW'($signed(s_scale[k]));
        end
      end
      if (free2) begin
        v2 <= v1;
        if (v1) begin
          m_data <= y_d;
          m_last <= last1;
        end
      end
      if (free2 && v1 && |sat_d) sat_flag <= 1'b1;
      else if (sat_clr) sat_flag <= 1'b0;
    end
  end
endmodule
